// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants, state encoding and entry type for the fetch front end
package inst_fetch_pkg;

  localparam logic RST_ENABLE  = 1'b1;
  localparam int   INST_ADDR_W = 32;
  localparam int   INST_W      = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  // IDLE: nothing outstanding; WAIT: request live, response kept;
  // DROP: request live, response will be thrown away after a redirect.
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_WAIT = 2'b01,
    FETCH_DROP = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  // Sequential word address; wraps naturally at the top of the address space.
  function automatic logic [INST_ADDR_W-1:0] next_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + INST_ADDR_W'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of {pc, inst} fetch entries
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output fetch_entry_t           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A simultaneous pop frees the slot a push into a full FIFO would need.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy update; flush wins over push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - MIPS32 instruction fetch: PC, ROM handshake, fetch buffer, branch redirect
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                     FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  output logic                   rom_req_o,
  output logic [INST_ADDR_W-1:0] rom_addr_o,
  input  logic                   rom_ack_i,
  input  logic [INST_W-1:0]      rom_data_i,
  output logic                   if_valid,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e           state_q, state_d;
  logic                   rom_req_q, rom_req_d;
  logic [INST_ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [INST_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [INST_ADDR_W-1:0] last_pc_q, last_pc_d;
  logic [INST_ADDR_W-1:0] drop_pc;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          count_next;
  logic                   slot_free;
  fetch_entry_t           fifo_wdata;
  fetch_entry_t           fifo_head;

  // A redirect overrides everything: no keep, no pop, buffer flushed.
  assign fifo_pop   = !fifo_empty && !stall_i && !branch_flag_i;
  assign fifo_push  = (state_q == FETCH_WAIT) && rom_ack_i && !branch_flag_i && !fifo_full;
  assign fifo_wdata = '{pc: rom_addr_q, inst: rom_data_i};

  // A new request is only issued if the buffer can still take its response,
  // so buffered entries plus the outstanding request never exceed the depth.
  assign count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
  assign slot_free  = (count_next < CW'(FIFO_DEPTH));

  // While dropping, a newer redirect replaces the pending restart address.
  assign drop_pc = branch_flag_i ? branch_target_i : fetch_pc_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (branch_flag_i),
    .data_i  (fifo_wdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // Fetch FSM next state, request/address/PC updates and last-shown PC.
  always_comb begin
    state_d    = state_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    fetch_pc_d = fetch_pc_q;
    last_pc_d  = fifo_empty ? last_pc_q : fifo_head.pc;
    case (state_q)
      FETCH_IDLE: begin
        if (branch_flag_i) begin
          state_d    = FETCH_WAIT;
          rom_req_d  = 1'b1;
          rom_addr_d = branch_target_i;
          fetch_pc_d = branch_target_i;
        end else if (slot_free) begin
          state_d    = FETCH_WAIT;
          rom_req_d  = 1'b1;
          rom_addr_d = fetch_pc_q;
        end
      end
      FETCH_WAIT: begin
        if (branch_flag_i) begin
          fetch_pc_d = branch_target_i;
          if (rom_ack_i) begin
            rom_addr_d = branch_target_i;
          end else begin
            state_d = FETCH_DROP;
          end
        end else if (rom_ack_i) begin
          fetch_pc_d = next_pc(rom_addr_q);
          if (slot_free) begin
            rom_addr_d = next_pc(rom_addr_q);
          end else begin
            state_d   = FETCH_IDLE;
            rom_req_d = 1'b0;
          end
        end
      end
      FETCH_DROP: begin
        fetch_pc_d = drop_pc;
        if (rom_ack_i) begin
          if (slot_free) begin
            state_d    = FETCH_WAIT;
            rom_addr_d = drop_pc;
          end else begin
            state_d   = FETCH_IDLE;
            rom_req_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = FETCH_IDLE;
        rom_req_d = 1'b0;
      end
    endcase
  end

  // State and handshake registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= FETCH_IDLE;
      rom_req_q  <= 1'b0;
      rom_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      last_pc_q  <= ZERO_WORD;
    end else begin
      state_q    <= state_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
      fetch_pc_q <= fetch_pc_d;
      last_pc_q  <= last_pc_d;
    end
  end

  assign rom_req_o  = rom_req_q;
  assign rom_addr_o = rom_addr_q;
  assign if_valid   = !fifo_empty;
  assign if_pc      = fifo_empty ? last_pc_q : fifo_head.pc;
  assign if_inst    = fifo_empty ? ZERO_WORD : fifo_head.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with a variable-latency ROM model
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_data_i;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   lat = 0;
  bit   force_ack = 1'b0;
  exp_t exp_q[$];

  inst_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom_req_o       (rom_req_o),
    .rom_addr_o      (rom_addr_o),
    .rom_ack_i       (rom_ack_i),
    .rom_data_i      (rom_data_i),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h2400_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back({pc, inst});
  endtask

  // Wait for the scoreboard to empty, then stall so nothing further is consumed.
  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        stall_i = 1'b1;
        return;
      end
    end
    n_cmp++;
    n_fail++;
    $display("FAIL drain_timeout: %0d entries still expected", exp_q.size());
    stall_i = 1'b1;
    exp_q.delete();
  endtask

  // Let the buffer fill under stall so the fetcher parks in IDLE.
  task automatic settle();
    lat = 0;
    repeat (6) @(negedge clk);
  endtask

  // ROM model: acks after lat idle cycles of a live request.
  initial begin
    int cnt;
    cnt = 0;
    rom_ack_i = 1'b0;
    rom_data_i = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (force_ack) begin
        rom_ack_i = 1'b1;
        rom_data_i = 32'hDEAD_BEEF;
        cnt = 0;
      end else if (rom_req_o) begin
        if (cnt >= lat) begin
          rom_ack_i = 1'b1;
          rom_data_i = rom_word(rom_addr_o);
          cnt = 0;
        end else begin
          rom_ack_i = 1'b0;
          rom_data_i = 32'h0;
          cnt++;
        end
      end else begin
        rom_ack_i = 1'b0;
        rom_data_i = 32'h0;
        cnt = 0;
      end
    end
  end

  // Monitor: pops and compares each consumed instruction.
  initial begin
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    exp_t        e;
    prev_hold = 1'b0;
    prev_pc = 32'h0;
    prev_inst = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (!if_valid) check("nop_inst", if_inst, 32'h0);
        if (prev_hold) begin
          check("hold_valid", 32'(if_valid), 32'h1);
          check("hold_pc", if_pc, prev_pc);
          check("hold_inst", if_inst, prev_inst);
        end
        if (if_valid && !stall_i && !branch_flag_i) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_inst: got pc %h inst %h expected none", if_pc, if_inst);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", if_pc, e.pc);
            check("out_inst", if_inst, e.inst);
          end
        end
        n_cmp++;
        if ((dut.state_q == FETCH_WAIT) && rom_req_o && rom_ack_i && !branch_flag_i && dut.fifo_full) begin
          n_fail++;
          $display("FAIL push_into_full: got full=1 expected full=0 at %0t", $time);
        end
      end
      prev_hold = !rst && if_valid && stall_i && !branch_flag_i;
      prev_pc = if_pc;
      prev_inst = if_inst;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    rst = 1'b1;
    stall_i = 1'b1;
    branch_flag_i = 1'b0;
    branch_target_i = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_req", 32'(rom_req_o), 32'h0);
    check("rst_addr", rom_addr_o, 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);

    // Zero-wait ROM, no stall
    exp_push(32'h00, 32'h2400_0000);
    exp_push(32'h04, 32'h2400_0004);
    exp_push(32'h08, 32'h2400_0008);
    exp_push(32'h0C, 32'h2400_000C);
    exp_push(32'h10, 32'h2400_0010);
    exp_push(32'h14, 32'h2400_0014);
    @(negedge clk);
    rst = 1'b0;
    stall_i = 1'b0;
    #2;
    check("zw_c0_req", 32'(rom_req_o), 32'h0);
    @(negedge clk); #2;
    check("zw_c1_req", 32'(rom_req_o), 32'h1);
    check("zw_c1_addr", rom_addr_o, 32'h0);
    check("zw_c1_valid", 32'(if_valid), 32'h0);
    @(negedge clk); #2;
    check("zw_c2_addr", rom_addr_o, 32'h4);
    check("zw_c2_valid", 32'(if_valid), 32'h1);
    @(negedge clk); #2;
    check("zw_c3_addr", rom_addr_o, 32'h8);
    drain();

    // Three-cycle ROM latency
    settle();
    exp_push(32'h40, 32'h2400_0040);
    exp_push(32'h44, 32'h2400_0044);
    exp_push(32'h48, 32'h2400_0048);
    lat = 3;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h40;
    stall_i = 1'b0;
    @(negedge clk);
    branch_flag_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      check("lat_req", 32'(rom_req_o), 32'h1);
      check("lat_addr_hold", rom_addr_o, 32'h40);
      check("lat_gap_valid", 32'(if_valid), 32'h0);
      @(negedge clk);
    end
    #2;
    check("lat_first_valid", 32'(if_valid), 32'h1);
    check("lat_next_addr", rom_addr_o, 32'h44);
    @(negedge clk); #2;
    check("lat_gap_after", 32'(if_valid), 32'h0);
    drain();

    // Stall held five cycles with zero-wait ROM
    settle();
    for (int k = 0; k < 8; k++) begin
      logic [31:0] a;
      a = 32'h200 + 32'(k * 4);
      exp_push(a, 32'h2400_0000 | a);
    end
    branch_flag_i = 1'b1;
    branch_target_i = 32'h200;
    stall_i = 1'b0;
    @(negedge clk);
    branch_flag_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    stall_i = 1'b1;
    #2;
    check("stall_pc_first", if_pc, 32'h204);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #2;
      check("stall_req_off", 32'(rom_req_o), 32'h0);
      check("stall_count", 32'(dut.fifo_count), 32'h2);
      check("stall_pc", if_pc, 32'h204);
      check("stall_inst", if_inst, 32'h2400_0204);
    end
    @(negedge clk);
    stall_i = 1'b0;
    drain();

    // Branch while a slow request to 0x10 is outstanding
    settle();
    exp_push(32'h000, 32'h2400_0000);
    exp_push(32'h004, 32'h2400_0004);
    exp_push(32'h008, 32'h2400_0008);
    exp_push(32'h00C, 32'h2400_000C);
    exp_push(32'h100, 32'h2400_0100);
    exp_push(32'h104, 32'h2400_0104);
    lat = 3;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h0;
    stall_i = 1'b0;
    @(negedge clk);
    branch_flag_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk); #2;
      if (rom_req_o && (rom_addr_o == 32'h10)) found = 1'b1;
    end
    check("find_req_0x10", 32'(found), 32'h1);
    @(negedge clk);
    branch_flag_i = 1'b1;
    branch_target_i = 32'h100;
    @(negedge clk);
    branch_flag_i = 1'b0;
    #2;
    check("drop_state", 32'(dut.state_q), 32'(FETCH_DROP));
    check("drop_req", 32'(rom_req_o), 32'h1);
    check("drop_addr_hold", rom_addr_o, 32'h10);
    check("drop_valid", 32'(if_valid), 32'h0);
    for (int n = 0; n < 20 && (rom_addr_o == 32'h10); n++) begin
      @(negedge clk); #2;
    end
    check("addr_after_drop", rom_addr_o, 32'h100);
    drain();

    // Branch together with ack while stalled
    settle();
    exp_push(32'h300, 32'h2400_0300);
    exp_push(32'h400, 32'h2400_0400);
    exp_push(32'h404, 32'h2400_0404);
    exp_push(32'h408, 32'h2400_0408);
    branch_flag_i = 1'b1;
    branch_target_i = 32'h300;
    stall_i = 1'b0;
    @(negedge clk);
    branch_flag_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    stall_i = 1'b1;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h400;
    @(negedge clk);
    branch_flag_i = 1'b0;
    stall_i = 1'b0;
    #2;
    check("bra_ack_req", 32'(rom_req_o), 32'h1);
    check("bra_ack_addr", rom_addr_o, 32'h400);
    check("bra_ack_valid", 32'(if_valid), 32'h0);
    drain();

    // Reset mid-WAIT, then a late ack while no request is live
    settle();
    lat = 3;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h500;
    stall_i = 1'b0;
    @(negedge clk);
    branch_flag_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_push(32'h0, 32'h2400_0000);
    exp_push(32'h4, 32'h2400_0004);
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    #2;
    check("mid_rst_req", 32'(rom_req_o), 32'h0);
    check("mid_rst_addr", rom_addr_o, 32'h0);
    check("mid_rst_valid", 32'(if_valid), 32'h0);
    check("mid_rst_pc", if_pc, 32'h0);
    @(negedge clk);
    force_ack = 1'b0;
    #2;
    check("post_rst_req", 32'(rom_req_o), 32'h1);
    check("post_rst_addr", rom_addr_o, 32'h0);
    check("post_rst_valid", 32'(if_valid), 32'h0);
    drain();

    // PC wrap at the top of the address space
    settle();
    exp_push(32'hFFFF_FFF8, 32'h2400_FFF8);
    exp_push(32'hFFFF_FFFC, 32'h2400_FFFC);
    exp_push(32'h0000_0000, 32'h2400_0000);
    exp_push(32'h0000_0004, 32'h2400_0004);
    branch_flag_i = 1'b1;
    branch_target_i = 32'hFFFF_FFF8;
    stall_i = 1'b0;
    @(negedge clk);
    branch_flag_i = 1'b0;
    #2;
    check("wrap_addr0", rom_addr_o, 32'hFFFF_FFF8);
    @(negedge clk); #2;
    check("wrap_addr1", rom_addr_o, 32'hFFFF_FFFC);
    @(negedge clk); #2;
    check("wrap_addr2", rom_addr_o, 32'h0000_0000);
    drain();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
